// File: rtl/unidad_control_pipeline.sv
// -----------------------------------------------------------------------------
// unidad_control_pipeline
//
// Pipeline sequencing controller for the 5-stage MIPS core. It drives the load
// enables and bubble-insert (flush) strobes of the PC and of the four pipeline
// registers BF0 (IF/ID), BF1 (ID/EX), BF2 (EX/MEM) and BF3 (MEM/WB), and it
// selects the PC source. It resolves three kinds of hazard:
//   - load-use hazards between EX and ID (one bubble),
//   - taken branches and jumps resolved at the BF2 outputs (three bubbles),
//   - multi-cycle data-memory accesses via req/ready, with a timeout error.
//
// Parameters
//   MEM_TIMEOUT   last MEM_WAIT counter value tolerated before ERROR (1..255)
//
// Ports
//   clk_UCP            clock, rising edge
//   rst_UCP            synchronous active-high reset (dominates all outputs)
//   MemRead_BF1        instruction in EX is a load
//   rt_BF1             load destination register in EX
//   rs_ID, rt_ID       source registers of the instruction in ID
//   useRt_ID           ID instruction reads rt
//   branch_BF2, zf_BF2, jump_BF2   control outputs of BF2
//   MemRead_BF2, MemWrite_BF2      memory operation in the MEM stage
//   mem_ready_UCP      data memory completes the access this cycle
//   pc_en_UCP          PC load enable
//   bfN_en_UCP         load enable of pipeline register N (0..3)
//   bfN_flush_UCP      load a bubble into register N (with its enable high)
//   pcSrc_UCP          00 PC+4, 01 branch target, 10 jump target
//   mem_req_UCP        memory access request
//   err_UCP            sticky memory-timeout error
//
// Optional feature (macro UCP_PERF_CNT_EN)
//   stallCnt_UCP       saturating count of cycles with the PC frozen
//   flushCnt_UCP       saturating count of taken-redirect cycles
// -----------------------------------------------------------------------------
module unidad_control_pipeline #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_UCP,
  input  logic       rst_UCP,
  input  logic       MemRead_BF1,
  input  logic [4:0] rt_BF1,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       useRt_ID,
  input  logic       branch_BF2,
  input  logic       zf_BF2,
  input  logic       jump_BF2,
  input  logic       MemRead_BF2,
  input  logic       MemWrite_BF2,
  input  logic       mem_ready_UCP,
  output logic       pc_en_UCP,
  output logic       bf0_en_UCP,
  output logic       bf1_en_UCP,
  output logic       bf2_en_UCP,
  output logic       bf3_en_UCP,
  output logic       bf0_flush_UCP,
  output logic       bf1_flush_UCP,
  output logic       bf2_flush_UCP,
  output logic       bf3_flush_UCP,
  output logic [1:0] pcSrc_UCP,
  output logic       mem_req_UCP,
  output logic       err_UCP
`ifdef UCP_PERF_CNT_EN
  ,
  output logic [15:0] stallCnt_UCP,
  output logic [15:0] flushCnt_UCP
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;

  // Hazard conditions, all evaluated in the cycle they become visible.
  logic mem_op, taken, load_use, redirect;

  assign mem_op   = MemRead_BF2 | MemWrite_BF2;
  assign taken    = (branch_BF2 & zf_BF2) | jump_BF2;
  // Register 0 is hard-wired to zero, so a load into it never creates a hazard.
  assign load_use = MemRead_BF1 & (rt_BF1 != 5'd0) &
                    ((rt_BF1 == rs_ID) | (useRt_ID & (rt_BF1 == rt_ID)));

  // A redirect only happens when RUN takes the branch/jump path.
  assign redirect = !rst_UCP && (state == RUN) && !mem_op && taken;

  // ---------------------------------------------------------------------------
  // State and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_UCP) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (rst_UCP) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and combinational strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_en_UCP     = 1'b1;
    bf0_en_UCP    = 1'b1;
    bf1_en_UCP    = 1'b1;
    bf2_en_UCP    = 1'b1;
    bf3_en_UCP    = 1'b1;
    bf0_flush_UCP = 1'b0;
    bf1_flush_UCP = 1'b0;
    bf2_flush_UCP = 1'b0;
    bf3_flush_UCP = 1'b0;
    pcSrc_UCP     = PC_SEQ;
    mem_req_UCP   = 1'b0;
    err_UCP       = 1'b0;

    if (rst_UCP) begin
      // Fill the whole pipeline with bubbles while holding the PC. Any pending
      // memory access is abandoned, so the request drops immediately.
      pc_en_UCP     = 1'b0;
      bf0_flush_UCP = 1'b1;
      bf1_flush_UCP = 1'b1;
      bf2_flush_UCP = 1'b1;
      bf3_flush_UCP = 1'b1;
      state_next    = RUN;
      wait_cnt_next = 8'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_op) begin
            mem_req_UCP = 1'b1;
            if (!mem_ready_UCP) begin
              // Freeze everything up to EX/MEM; MEM/WB gets a bubble so the
              // stalled access is not written back more than once.
              pc_en_UCP     = 1'b0;
              bf0_en_UCP    = 1'b0;
              bf1_en_UCP    = 1'b0;
              bf2_en_UCP    = 1'b0;
              bf3_flush_UCP = 1'b1;
              state_next    = MEM_WAIT;
              wait_cnt_next = 8'd0;
            end
          end else if (taken) begin
            // Kill the three younger wrong-path instructions; MEM/WB keeps
            // advancing with the older instruction.
            pcSrc_UCP     = jump_BF2 ? PC_JUMP : PC_BRANCH;
            bf0_flush_UCP = 1'b1;
            bf1_flush_UCP = 1'b1;
            bf2_flush_UCP = 1'b1;
          end else if (load_use) begin
            // Hold IF and ID for one cycle and push a bubble into EX; the load
            // moves on to MEM on this edge, so one bubble is always enough.
            pc_en_UCP     = 1'b0;
            bf0_en_UCP    = 1'b0;
            bf1_flush_UCP = 1'b1;
          end
        end

        MEM_WAIT: begin
          mem_req_UCP = 1'b1;
          if (mem_ready_UCP) begin
            // Completion wins even on the timeout cycle.
            state_next = RUN;
          end else begin
            pc_en_UCP     = 1'b0;
            bf0_en_UCP    = 1'b0;
            bf1_en_UCP    = 1'b0;
            bf2_en_UCP    = 1'b0;
            bf3_flush_UCP = 1'b1;
            if (wait_cnt == TIMEOUT_CNT) begin
              state_next = ERROR;
            end else begin
              wait_cnt_next = wait_cnt + 8'd1;
            end
          end
        end

        ERROR: begin
          pc_en_UCP  = 1'b0;
          bf0_en_UCP = 1'b0;
          bf1_en_UCP = 1'b0;
          bf2_en_UCP = 1'b0;
          bf3_en_UCP = 1'b0;
          err_UCP    = 1'b1;
        end

        default: begin
          // Unreachable encoding: recover into the error state so it is seen.
          state_next = ERROR;
        end
      endcase
    end
  end

`ifdef UCP_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic stall_evt;

  // ERROR also holds the PC, but that is a fault rather than a stall.
  assign stall_evt = !rst_UCP && (state != ERROR) && !pc_en_UCP;

  always_ff @(posedge clk_UCP) begin
    if (rst_UCP) begin
      stallCnt_UCP <= 16'd0;
      flushCnt_UCP <= 16'd0;
    end else begin
      if (stall_evt && (stallCnt_UCP != 16'hFFFF)) begin
        stallCnt_UCP <= stallCnt_UCP + 16'd1;
      end
      if (redirect && (flushCnt_UCP != 16'hFFFF)) begin
        flushCnt_UCP <= flushCnt_UCP + 16'd1;
      end
    end
  end
`else
  // The redirect term only feeds the counters.
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: doc/unidad_control_pipeline.md
# unidad_control_pipeline

Pipeline sequencing controller for the 5-stage MIPS core. Drives load-enable and flush (bubble-insert) strobes for the PC and the four pipeline registers BF0 (IF/ID), BF1 (ID/EX), BF2 (EX/MEM) and BF3 (MEM/WB), plus the PC-source select. Resolves load-use hazards, taken branches and jumps resolved at the BF2 outputs, and multi-cycle data-memory accesses via a req/ready handshake with timeout.

## Interface
- MEM_TIMEOUT, 15: max cycles in MEM_WAIT before error (1..255).
- clk_UCP  in  1  clock, rising edge.
- rst_UCP  in  1  synchronous, active-high reset.
- MemRead_BF1  in  1  instruction in EX is a load.
- rt_BF1  in  5  load destination register in EX.
- rs_ID, rt_ID  in  5 each  source registers of the instruction in ID.
- useRt_ID  in  1  ID instruction reads rt.
- branch_BF2, zf_BF2, jump_BF2  in  1 each  BF2 control outputs.
- MemRead_BF2, MemWrite_BF2  in  1 each  memory op in MEM stage.
- mem_ready_UCP  in  1  data memory completes the access this cycle.
- pc_en_UCP  out  1  PC load enable.
- bf0_en_UCP, bf1_en_UCP, bf2_en_UCP, bf3_en_UCP  out  1 each  register load enables.
- bf0_flush_UCP, bf1_flush_UCP, bf2_flush_UCP, bf3_flush_UCP  out  1 each  load a bubble (all controls 0) instead of the input; only meaningful with the matching enable high.
- pcSrc_UCP  out  2  00 PC+4, 01 branch target (resAdd1), 10 jump target (concatenator); 11 unused.
- mem_req_UCP  out  1  memory access request.
- err_UCP  out  1  sticky memory-timeout error.

## Operation
- States: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; state and wait counter are registered.
- memOp = MemRead_BF2 | MemWrite_BF2. taken = (branch_BF2 & zf_BF2) | jump_BF2. lu = MemRead_BF1 & (rt_BF1 != 0) & ((rt_BF1 == rs_ID) | (useRt_ID & rt_BF1 == rt_ID)).
- Default in RUN (no event): all enables 1, all flushes 0, pcSrc 00, mem_req 0.
- Priority in RUN: memOp > taken > lu.
- RUN, memOp: mem_req=1. If mem_ready=1: normal advance and stay in RUN. Else: pc_en, bf0_en, bf1_en, bf2_en = 0; bf3_en=1 with bf3_flush=1; go to MEM_WAIT and clear the counter.
- MEM_WAIT: mem_req=1, same freeze pattern. The counter increments each cycle. On mem_ready: normal advance (all enables 1, no flush) and go to RUN. When the counter reaches MEM_TIMEOUT with mem_ready low: go to ERROR.
- RUN, taken (no memOp): pcSrc = 10 if jump_BF2, else 01 (jump wins if both). pc_en=1. bf0/bf1/bf2 flush = 1 (kills the 3 wrong-path instructions). bf3 advances normally.
- RUN, lu (no memOp, no taken): pc_en=0, bf0_en=0, bf1_en=1 with bf1_flush=1; bf2/bf3 advance. Exactly one bubble is inserted, because the load leaves EX on the next edge.
- ERROR: all enables 0, mem_req=0, err=1. The block stays in ERROR until reset.
- Reset asserted (dominates all): state=RUN, counter=0, err=0, pc_en=0, mem_req=0, pcSrc=00, all bf*_en=1 and bf*_flush=1. The pipeline fills with bubbles. Reset mid-MEM_WAIT aborts the access; mem_req drops in the reset cycle.

## Timing
- All hazard responses take effect at the same clock edge on which the condition is visible (0-cycle decision latency).
- Load-use penalty: 1 cycle. Taken branch/jump penalty: 3 cycles. Memory stall: cycles until mem_ready.
- mem_ready sampled high on the first RUN cycle → no stall, no state change.
- Counter is 8 bits. ERROR is entered on the edge where counter == MEM_TIMEOUT and mem_ready=0, i.e. MEM_TIMEOUT+1 cycles after entering MEM_WAIT. mem_ready in that same cycle wins, and the block goes to RUN.
- First cycle after reset deassertion is RUN with normal behaviour.

## Configuration
- UCP_PERF_CNT_EN defined: adds outputs stallCnt_UCP[15:0] and flushCnt_UCP[15:0], both cleared by reset and saturating at 0xFFFF.
  - stallCnt increments each cycle pc_en=0 outside reset and ERROR.
  - flushCnt increments once per taken-redirect cycle.
- UCP_PERF_CNT_EN not defined: the ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Reset 2 cycles → pc_en=0, all en=1, all flush=1, err=0. After release with no hazards → all en=1, flush=0, pcSrc=00.
- MemRead_BF1=1, rt_BF1=8, rs_ID=8 → one cycle of pc_en=0, bf0_en=0, bf1_flush=1. Repeat with rt_BF1=0 → no stall.
- branch_BF2=1, zf_BF2=1 → pcSrc=01, bf0/1/2_flush=1 for one cycle. jump_BF2=1 → pcSrc=10. Branch with zf=0 → pcSrc=00, no flush.
- MemRead_BF2=1, mem_ready low for 3 cycles then high → 3 frozen cycles with bf3_flush=1, then advance; mem_req high all 4 cycles. Simultaneous lu during the stall → memory freeze pattern wins.
- MEM_TIMEOUT=4, MemWrite_BF2=1, mem_ready never → ERROR after 5 cycles, err=1, all en=0. Reset clears err.
- UCP_PERF_CNT_EN: after scenario 3 (branch) → flushCnt=1. After scenario 4 → stallCnt=3. Counter preloaded near max → holds at 0xFFFF.
